y_signature_compactor: RTL and testbench



---
 rtl/y_signature_compactor.sv | 87 ++++++++
 tb/tb_y_signature_compactor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/y_signature_compactor.sv
// y_signature_compactor: folds each accepted 192-bit y sample into a 32-bit MISR and emits one signature per window.
// Optional SIG_CYCLE_STAMP_EN adds sig_cycle, the cycle count latched at window completion.
module y_signature_compactor #(
    parameter int               DATA_W = 192,
    parameter int               SIG_W  = 32,
    parameter int               WINDOW = 256,
    parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic [SIG_W-1:0]  sig_data,
    output logic [15:0]       sig_index,
    output logic              busy,
    output logic              overflow
`ifdef SIG_CYCLE_STAMP_EN
    ,output logic [31:0]      sig_cycle
`endif
);
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic [SIG_W-1:0] r_misr, r_sig_data, w_fold, w_misr_next;
    logic [15:0]      r_count, r_win, r_sig_index;
    logic             r_state, r_overflow, w_done, w_xfer, w_load;

    always_comb begin
        w_fold = '0;
        for (int k = 0; k < DATA_W / SIG_W; k++) w_fold = w_fold ^ in_data[k*SIG_W +: SIG_W];
    end

    assign w_misr_next = {r_misr[SIG_W-2:0], 1'b0} ^ (r_misr[SIG_W-1] ? POLY : '0) ^ w_fold;
    assign w_done      = in_valid && (r_count == 16'(WINDOW - 1));
    assign w_xfer      = (r_state == ST_FULL) && sig_ready;
    // the output register accepts a new signature when empty or emptying on this edge
    assign w_load      = w_done && ((r_state == ST_EMPTY) || sig_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misr      <= SEED;
            r_count     <= '0;
            r_win       <= '0;
            r_state     <= ST_EMPTY;
            r_sig_data  <= '0;
            r_sig_index <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (in_valid) begin
                r_misr  <= w_done ? SEED : w_misr_next;
                r_count <= w_done ? '0 : r_count + 16'd1;
            end
            if (w_done) r_win <= r_win + 16'd1;
            if (w_load) begin
                r_sig_data  <= w_misr_next;
                r_sig_index <= r_win;
                r_state     <= ST_FULL;
            end else if (w_xfer) begin
                r_state <= ST_EMPTY;
            end
            if (w_done && !w_load) r_overflow <= 1'b1;
        end
    end

`ifdef SIG_CYCLE_STAMP_EN
    logic [31:0] r_cycle, r_sig_cycle;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle     <= '0;
            r_sig_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_load) r_sig_cycle <= r_cycle;
        end
    end
    assign sig_cycle = r_sig_cycle;
`endif

    assign sig_valid = (r_state == ST_FULL);
    assign sig_data  = r_sig_data;
    assign sig_index = r_sig_index;
    assign busy      = (r_count != 16'd0);
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_y_signature_compactor.sv
// tb_y_signature_compactor: directed checks of four compactor instances with WINDOW = 1, 4, 2 and 3.
module tb_y_signature_compactor;
    logic         clk = 1'b0, rst_n = 1'b1;
    logic [191:0] d = '0;
    logic         iv1 = 0, iv2 = 0, iv3 = 0, iv4 = 0;
    logic         rd1 = 0, rd2 = 0, rd3 = 0, rd4 = 0;
    logic         sv1, sv2, sv3, sv4, bz1, bz2, bz3, bz4, of1, of2, of3, of4;
    logic [31:0]  sd1, sd2, sd3, sd4, m, w0;
    logic [15:0]  si1, si2, si3, si4;
`ifdef SIG_CYCLE_STAMP_EN
    logic [31:0]  cy1, cy2, cy3, cy4;
`endif
    int           n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    y_signature_compactor #(.WINDOW(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(d),
        .sig_valid(sv1), .sig_ready(rd1), .sig_data(sd1), .sig_index(si1), .busy(bz1), .overflow(of1)
`ifdef SIG_CYCLE_STAMP_EN
        , .sig_cycle(cy1)
`endif
    );
    y_signature_compactor #(.WINDOW(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_data(d),
        .sig_valid(sv2), .sig_ready(rd2), .sig_data(sd2), .sig_index(si2), .busy(bz2), .overflow(of2)
`ifdef SIG_CYCLE_STAMP_EN
        , .sig_cycle(cy2)
`endif
    );
    y_signature_compactor #(.WINDOW(3)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_data(d),
        .sig_valid(sv3), .sig_ready(rd3), .sig_data(sd3), .sig_index(si3), .busy(bz3), .overflow(of3)
`ifdef SIG_CYCLE_STAMP_EN
        , .sig_cycle(cy3)
`endif
    );
    y_signature_compactor #(.WINDOW(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_data(d),
        .sig_valid(sv4), .sig_ready(rd4), .sig_data(sd4), .sig_index(si4), .busy(bz4), .overflow(of4)
`ifdef SIG_CYCLE_STAMP_EN
        , .sig_cycle(cy4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s, input logic [191:0] x);
        logic [31:0] f = '0;
        for (int k = 0; k < 6; k++) f = f ^ x[k*32 +: 32];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #3;
        check("rst_valid", sv1, 0);
        check("rst_data", sd1, 0);
        check("rst_index", si1, 0);
        check("rst_busy", bz4, 0);
        check("rst_ovf", of2, 0);
        #2 rst_n = 1'b1;
        tick();
        // WINDOW=1, zero sample
        rd1 = 1; iv1 = 1; d = '0;
        tick();
        iv1 = 0;
        check("w1_zero_valid", sv1, 1);
        check("w1_zero_data", sd1, 32'hFB3EE249);
        check("w1_zero_index", si1, 0);
        tick();
        check("w1_drop_valid", sv1, 0);
        // fold: bit 0 and bit 160 land on the same signature bit
        iv1 = 1; d = 192'h1;
        tick();
        check("w1_bit0_data", sd1, 32'hFB3EE248);
        check("w1_bit0_index", si1, 1);
        d = '0; d[160] = 1'b1;
        tick();
        iv1 = 0;
        check("w1_bit160_valid", sv1, 1);
        check("w1_bit160_data", sd1, 32'hFB3EE248);
        check("w1_bit160_index", si1, 2);
        tick();
        check("w1_idle_valid", sv1, 0);
        // WINDOW=4 with gaps
        rd4 = 1; m = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            d = {64'(i * 3 + 1), 64'(i + 11), 64'(i * 5 + 2)};
            iv4 = 1; m = step(m, d);
            tick();
            iv4 = 0;
            if (i == 0) check("w4_busy_s1", bz4, 1);
            if (i < 3) check("w4_no_sig", sv4, 0);
            if (i == 3) begin
                check("w4_valid", sv4, 1);
                check("w4_data", sd4, m);
                check("w4_index", si4, 0);
                check("w4_busy_s4", bz4, 0);
            end
            tick();
            tick();
        end
        check("w4_once", sv4, 0);
        // WINDOW=2 with backpressure and overflow
        rd2 = 0; m = 32'hFFFFFFFF; w0 = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin
                rd2 = 1;
                tick();
                check("w2_xfer_drop", sv2, 0);
            end
            d = {32'(i), 32'hA5A5_0000 + 32'(i), 64'(i * 7), 64'hDEAD + 64'(i)};
            iv2 = 1; m = step(m, d);
            tick();
            iv2 = 0;
            if (i == 1) w0 = m;
            if (i % 2 == 1 && i < 7) m = 32'hFFFFFFFF;
            if (i == 1) check("w2_first_data", sd2, w0);
            if (i == 2) check("w2_ovf_clear", of2, 0);
            if (i == 3) check("w2_ovf_set", of2, 1);
            if (i == 5) begin
                check("w2_hold_valid", sv2, 1);
                check("w2_hold_data", sd2, w0);
                check("w2_hold_index", si2, 0);
            end
            if (i == 7) begin
                check("w2_next_valid", sv2, 1);
                check("w2_next_index", si2, 3);
                check("w2_next_data", sd2, m);
            end
        end
        // WINDOW=3, reset mid-window
        rd3 = 1;
        for (int i = 0; i < 2; i++) begin
            d = {6{32'(i + 1) * 32'h1111}};
            d[0] = 1'b1;
            iv3 = 1;
            tick();
        end
        iv3 = 0;
        check("w3_busy_pre", bz3, 1);
        rst_n = 0;
        #2;
        check("w3_rst_busy", bz3, 0);
        check("w3_rst_valid", sv3, 0);
        check("w3_rst_ovf2", of2, 0);
        check("w3_rst_valid2", sv2, 0);
        check("w3_rst_index2", si2, 0);
        #4 rst_n = 1;
        m = 32'hFFFFFFFF; d = '0;
        for (int i = 0; i < 3; i++) begin
            iv3 = 1; m = step(m, d);
            tick();
            iv3 = 0;
            if (i == 1) check("w3_partial", sv3, 0);
        end
        check("w3_valid", sv3, 1);
        check("w3_index", si3, 0);
        check("w3_data", sd3, m);
`ifdef SIG_CYCLE_STAMP_EN
        rst_n = 0;
        #4 rst_n = 1;
        repeat (5) tick();
        rd1 = 0; iv1 = 1;
        tick();
        iv1 = 0;
        check("cyc_stamp", cy1, 5);
        tick();
        tick();
        check("cyc_hold", cy1, 5);
        check("cyc_hold_valid", sv1, 1);
        rd1 = 1;
        tick();
        check("cyc_xfer", sv1, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
